// File: rtl/final_cpa_accumulate.sv
// Final carry-propagate adder for a multiplier's compressed rows, followed by a
// saturating dot-product accumulator. It is a three-stage pipeline that stalls as a whole.
module final_cpa_accumulate #(
  parameter int BITWIDTH  = 8,
  parameter int ACC_WIDTH = 24
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [2*BITWIDTH-1:0]   row_a,
  input  logic [2*BITWIDTH-1:0]   row_b,
  input  logic                    in_first,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ACC_WIDTH-1:0]    acc_out,
  output logic                    out_sat
);

  localparam logic [ACC_WIDTH:0] ACC_MAX = {1'b0, {ACC_WIDTH{1'b1}}};

  logic                    s1_valid_q, s1_valid_d;
  logic [BITWIDTH:0]       s1_lo_q, s1_lo_d;
  logic [BITWIDTH-1:0]     s1_hi_a_q, s1_hi_a_d;
  logic [BITWIDTH-1:0]     s1_hi_b_q, s1_hi_b_d;
  logic                    s1_first_q, s1_first_d;
  logic                    s1_last_q, s1_last_d;

  logic                    s2_valid_q, s2_valid_d;
  logic [2*BITWIDTH-1:0]   s2_prod_q, s2_prod_d;
  logic                    s2_first_q, s2_first_d;
  logic                    s2_last_q, s2_last_d;

  logic [ACC_WIDTH-1:0]    acc_q, acc_d;
  logic                    sat_q, sat_d;
  logic [ACC_WIDTH-1:0]    acc_out_q, acc_out_d;
  logic                    out_sat_q, out_sat_d;
  logic                    out_valid_q, out_valid_d;

  logic                    advance_s;
  logic [BITWIDTH-1:0]     hi_sum_s;
  logic [ACC_WIDTH:0]      base_s;
  logic [ACC_WIDTH:0]      sum_s;
  logic [ACC_WIDTH-1:0]    acc_new_s;
  logic                    sat_new_s;

  always_comb begin
    if (rst) begin
      in_ready = 1'b0;
    end else begin
      in_ready = ~(out_valid_q & ~out_ready);
    end
  end

  assign advance_s = in_ready;
  assign out_valid = out_valid_q;
  assign acc_out   = acc_out_q;
  assign out_sat   = out_sat_q;

  // Split the carry-propagate add in half: low half with carry-out, then high half.
  always_comb begin
    s1_valid_d = advance_s ? in_valid : s1_valid_q;
    s1_lo_d    = advance_s ? ({1'b0, row_a[BITWIDTH-1:0]} + {1'b0, row_b[BITWIDTH-1:0]}) : s1_lo_q;
    s1_hi_a_d  = advance_s ? row_a[2*BITWIDTH-1:BITWIDTH] : s1_hi_a_q;
    s1_hi_b_d  = advance_s ? row_b[2*BITWIDTH-1:BITWIDTH] : s1_hi_b_q;
    s1_first_d = advance_s ? in_first : s1_first_q;
    s1_last_d  = advance_s ? in_last : s1_last_q;

    hi_sum_s   = s1_hi_a_q + s1_hi_b_q + {{(BITWIDTH-1){1'b0}}, s1_lo_q[BITWIDTH]};
    s2_valid_d = advance_s ? s1_valid_q : s2_valid_q;
    s2_prod_d  = advance_s ? {hi_sum_s, s1_lo_q[BITWIDTH-1:0]} : s2_prod_q;
    s2_first_d = advance_s ? s1_first_q : s2_first_q;
    s2_last_d  = advance_s ? s1_last_q : s2_last_q;
  end

  // Accumulate with clipping; a first term restarts both the sum and the sticky flag.
  always_comb begin
    base_s = s2_first_q ? {(ACC_WIDTH+1){1'b0}} : {1'b0, acc_q};
    sum_s  = base_s + {{(ACC_WIDTH+1-2*BITWIDTH){1'b0}}, s2_prod_q};
    if (sum_s > ACC_MAX) begin
      acc_new_s = {ACC_WIDTH{1'b1}};
      sat_new_s = 1'b1;
    end else begin
      acc_new_s = sum_s[ACC_WIDTH-1:0];
      sat_new_s = s2_first_q ? 1'b0 : sat_q;
    end

    acc_d       = acc_q;
    sat_d       = sat_q;
    acc_out_d   = acc_out_q;
    out_sat_d   = out_sat_q;
    out_valid_d = out_valid_q & ~out_ready;
    if (advance_s && s2_valid_q) begin
      if (s2_last_q) begin
        acc_d       = {ACC_WIDTH{1'b0}};
        sat_d       = 1'b0;
        acc_out_d   = acc_new_s;
        out_sat_d   = sat_new_s;
        out_valid_d = 1'b1;
      end else begin
        acc_d = acc_new_s;
        sat_d = sat_new_s;
      end
    end else begin
      acc_d = acc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_lo_q     <= {(BITWIDTH+1){1'b0}};
      s1_hi_a_q   <= {BITWIDTH{1'b0}};
      s1_hi_b_q   <= {BITWIDTH{1'b0}};
      s1_first_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_prod_q   <= {(2*BITWIDTH){1'b0}};
      s2_first_q  <= 1'b0;
      s2_last_q   <= 1'b0;
      acc_q       <= {ACC_WIDTH{1'b0}};
      sat_q       <= 1'b0;
      acc_out_q   <= {ACC_WIDTH{1'b0}};
      out_sat_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_lo_q     <= s1_lo_d;
      s1_hi_a_q   <= s1_hi_a_d;
      s1_hi_b_q   <= s1_hi_b_d;
      s1_first_q  <= s1_first_d;
      s1_last_q   <= s1_last_d;
      s2_valid_q  <= s2_valid_d;
      s2_prod_q   <= s2_prod_d;
      s2_first_q  <= s2_first_d;
      s2_last_q   <= s2_last_d;
      acc_q       <= acc_d;
      sat_q       <= sat_d;
      acc_out_q   <= acc_out_d;
      out_sat_q   <= out_sat_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_final_cpa_accumulate.sv
// Randomized and directed bench for final_cpa_accumulate, scored against an
// arithmetic dot-product model updated at term acceptance.
module tb_final_cpa_accumulate;
  localparam int BW = 8;
  localparam int AW = 18;
  localparam longint MAXV = 64'd262143;

  logic clk = 1'b0;
  logic rst, in_valid, in_ready, in_first, in_last, out_valid, out_ready, out_sat;
  logic [2*BW-1:0] row_a, row_b;
  logic [AW-1:0] acc_out;

  final_cpa_accumulate #(.BITWIDTH(BW), .ACC_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .row_a(row_a), .row_b(row_b), .in_first(in_first), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .acc_out(acc_out), .out_sat(out_sat)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [AW:0] exp_q[$];
  longint m_acc = 0;
  bit m_sat = 1'b0;
  bit hold_prev = 1'b0;
  logic [AW-1:0] hold_acc;
  logic hold_sat;
  logic [AW-1:0] last_acc;
  logic last_sat;
  int n_results = 0;
  bit ov_seen;
  bit accepted;
  int tag_val;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: modular row sum, restart on first, clip and stick, emit on last.
  task automatic model_accept(input logic [2*BW-1:0] a, input logic [2*BW-1:0] b,
                              input bit f, input bit l);
    longint s;
    logic [AW-1:0] v;
    s = (longint'(a) + longint'(b)) % 65536;
    if (f) begin
      m_acc = 0;
      m_sat = 1'b0;
    end
    m_acc = m_acc + s;
    if (m_acc > MAXV) begin
      m_acc = MAXV;
      m_sat = 1'b1;
    end
    if (l) begin
      v = m_acc[AW-1:0];
      exp_q.push_back({m_sat, v});
      m_acc = 0;
      m_sat = 1'b0;
    end
  endtask

  task automatic step(input bit v, input logic [2*BW-1:0] a, input logic [2*BW-1:0] b,
                      input bit f, input bit l, input bit ordy, output bit acc);
    logic [AW:0] e;
    @(negedge clk);
    in_valid = v; row_a = a; row_b = b; in_first = f; in_last = l; out_ready = ordy;
    #1;
    ov_seen = out_valid;
    check_eq("in_ready", in_ready, !(out_valid && !out_ready));
    if (hold_prev) begin
      check_eq("hold_acc", acc_out, hold_acc);
      check_eq("hold_sat", out_sat, hold_sat);
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious_result", out_valid, 0);
      end else begin
        e = exp_q.pop_front();
        check_eq("acc_out", acc_out, e[AW-1:0]);
        check_eq("out_sat", out_sat, e[AW]);
        last_acc = acc_out;
        last_sat = out_sat;
        n_results++;
      end
    end
    hold_prev = out_valid && !out_ready;
    hold_acc = acc_out;
    hold_sat = out_sat;
    acc = v && in_ready;
    @(posedge clk);
    if (acc) model_accept(a, b, f, l);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    #1;
    check_eq("rst_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_acc_out", acc_out, 0);
    check_eq("rst_out_sat", out_sat, 0);
    exp_q.delete();
    m_acc = 0;
    m_sat = 1'b0;
    hold_prev = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, accepted);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; row_a = 16'h0000; row_b = 16'h0000;
    in_first = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    do_reset();

    // Single term with latency check
    step(1'b1, 16'h00FF, 16'h0001, 1'b1, 1'b1, 1'b1, accepted);
    check_eq("t1_accept", accepted, 1);
    for (int k = 1; k <= 3; k++) begin
      step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, accepted);
      check_eq("latency", ov_seen, (k == 3));
    end
    check_eq("single_val", last_acc, 18'h00100);
    check_eq("single_sat", last_sat, 0);

    step(1'b1, 16'd50, 16'd50, 1'b1, 1'b0, 1'b1, accepted);
    step(1'b1, 16'd150, 16'd50, 1'b0, 1'b0, 1'b1, accepted);
    step(1'b1, 16'd100, 16'd200, 1'b0, 1'b1, 1'b1, accepted);
    idle(4);
    check_eq("three_term", last_acc, 18'd600);
    check_eq("three_sat", last_sat, 0);

    for (int i = 0; i < 5; i++)
      step(1'b1, 16'hFFFF, 16'h0000, (i == 0), (i == 4), 1'b1, accepted);
    idle(4);
    check_eq("sat_val", last_acc, 18'h3FFFF);
    check_eq("sat_flag", last_sat, 1);
    step(1'b1, 16'd3, 16'd4, 1'b1, 1'b1, 1'b1, accepted);
    idle(4);
    check_eq("after_sat_val", last_acc, 18'd7);
    check_eq("after_sat_flag", last_sat, 0);

    step(1'b1, 16'hFFFF, 16'h0002, 1'b1, 1'b1, 1'b1, accepted);
    idle(4);
    check_eq("wrap", last_acc, 18'h00001);

    // Backpressure: result pending with out_ready low stalls the whole pipe
    tag_val = 1;
    for (int i = 0; i < 14; i++) begin
      step(1'b1, 16'(tag_val), 16'h0000, 1'b1, 1'b1, 1'b0, accepted);
      if (i >= 4) check_eq("bp_stall", accepted, 0);
      if (accepted) tag_val++;
    end
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 16'(tag_val), 16'h0000, 1'b1, 1'b1, 1'b1, accepted);
      if (accepted) tag_val++;
    end
    idle(5);
    check_eq("bp_none_lost", exp_q.size(), 0);
    check_eq("bp_last", last_acc, tag_val - 1);

    // Reset mid dot product
    step(1'b1, 16'd10, 16'd0, 1'b1, 1'b0, 1'b1, accepted);
    step(1'b1, 16'd20, 16'd0, 1'b0, 1'b0, 1'b1, accepted);
    do_reset();
    tag_val = n_results;
    step(1'b1, 16'd2, 16'd3, 1'b1, 1'b1, 1'b1, accepted);
    idle(5);
    check_eq("rst_mid_count", n_results - tag_val, 1);
    check_eq("rst_mid_val", last_acc, 18'd5);

    // Random traffic
    for (int i = 0; i < 500; i++) begin
      logic [15:0] ra, rb;
      ra = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
      rb = 16'($urandom);
      step(($urandom_range(0, 3) != 0), ra, rb, ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0), accepted);
    end
    idle(8);
    check_eq("drain_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/final_cpa_accumulate.md
FINAL_CPA_ACCUMULATE -- requirements
Module: final_cpa_accumulate

Parameters
REQ-001 The module SHALL have parameter BITWIDTH, default 8, giving the operand width of the multiplier feeding the block.
REQ-002 The module SHALL have parameter ACC_WIDTH, default 24, giving the accumulator width; legal values are ACC_WIDTH >= 2*BITWIDTH.

Interface
REQ-003 clk  in  1  the single clock; all state SHALL update on its rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 in_valid  in  1  a term is presented on row_a/row_b/in_first/in_last.
REQ-006 in_ready  out  1  the block accepts the term this cycle; combinational, equal to NOT(out_valid AND NOT out_ready), forced 0 while rst=1.
REQ-007 row_a  in  2*BITWIDTH  sum row from the column compression tree.
REQ-008 row_b  in  2*BITWIDTH  carry row from the column compression tree, already bit-aligned with row_a.
REQ-009 in_first  in  1  this term starts a new dot product.
REQ-010 in_last  in  1  this term ends the current dot product.
REQ-011 out_valid  out  1  acc_out/out_sat hold a completed dot product.
REQ-012 out_ready  in  1  the consumer takes the result.
REQ-013 acc_out  out  ACC_WIDTH  completed dot-product value, unsigned.
REQ-014 out_sat  out  1  acc_out was clipped during this dot product.

Function
REQ-015 A term SHALL be accepted on every cycle where in_valid=1 and in_ready=1.
REQ-016 Define advance = in_ready; all pipeline registers SHALL load only when advance=1 and SHALL hold otherwise (full-pipeline stall, no bubble collapse).
REQ-017 Stage 1 SHALL register lo = row_a[BITWIDTH-1:0] + row_b[BITWIDTH-1:0] (BITWIDTH+1 bits), the upper halves of both rows, first, last, and a valid bit.
REQ-018 Stage 2 SHALL register product = {upper_a + upper_b + lo carry, lo[BITWIDTH-1:0]} truncated to 2*BITWIDTH bits, i.e. (row_a + row_b) mod 2^(2*BITWIDTH), with first, last and valid.
REQ-019 Stage 3 SHALL, on a valid stage-2 entry, set acc to zero-extended product if first=1, else to acc + product.
REQ-020 If the stage-3 sum exceeds 2^ACC_WIDTH-1, acc SHALL be set to 2^ACC_WIDTH-1 and the sticky saturation flag SHALL be set; first=1 SHALL clear the flag before that term is applied.
REQ-021 On a valid stage-2 entry with last=1, acc_out and out_sat SHALL load the resulting acc and flag, and out_valid SHALL be 1 the next cycle; acc and the flag SHALL then return to 0.
REQ-022 A term with first=0 following a completed dot product SHALL accumulate onto 0.
REQ-023 A term with first=1 and last=1 SHALL produce a single-term result.
REQ-024 Latency: a last term accepted at the edge ending cycle N SHALL give out_valid=1 in cycle N+3 when there is no stall.
REQ-025 out_valid SHALL clear after a cycle with out_valid=1 and out_ready=1, unless a new last term completes on that edge, in which case it SHALL stay 1 with the new value.
REQ-026 acc_out and out_sat SHALL be stable while out_valid=1 and out_ready=0.
REQ-027 Throughput SHALL be one term per cycle when out_ready is held high.

Reset
REQ-028 While rst=1, all stage valid bits, acc, the saturation flag, acc_out, out_sat and out_valid SHALL be 0 on the next edge.
REQ-029 A rst asserted mid-dot-product SHALL discard all in-flight terms and the partial sum, and SHALL emit no result for them.

Verification
REQ-030 BITWIDTH=8, ACC_WIDTH=18: row_a=0x00FF, row_b=0x0001, first=last=1 -> out_valid in cycle N+3, acc_out=0x00100, out_sat=0.
REQ-031 Three back-to-back terms with row sums 100, 200 and 300 (first on the 1st term, last on the 3rd) -> a single result, acc_out=600, out_sat=0.
REQ-032 Five terms of row_a=0xFFFF, row_b=0x0000 (first on the 1st, last on the 5th) -> acc_out=0x3FFFF, out_sat=1; a following first=last=1 term of sum 7 -> acc_out=7, out_sat=0.
REQ-033 Wrap: row_a=0xFFFF, row_b=0x0002, first=last=1 -> acc_out=0x00001.
REQ-034 Backpressure: hold out_ready=0 with a result pending and in_valid=1 -> in_ready=0, acc_out stable for 10 cycles; release out_ready -> every subsequent term is accepted once, with none lost or duplicated.
REQ-035 Reset mid-operation: accept two terms, then rst=1 for one cycle, then a first=last=1 term of sum 5 -> no result for the earlier terms, acc_out=5.
